conv_window_gen: RTL and testbench



---
 rtl/conv_window_gen.sv | 174 +++++++++++++++++
 tb/tb_conv_window_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream -> flattened 3x3 "no padding" windows.
// Two line buffers hold the previous two rows; a 3x3 shift register forms the window.
// Optional feature macro: CONV_WIN_COORD_EN adds win_row/win_col (window top-left).
module conv_window_gen #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     pix_in,
  input  logic                      pix_valid,
  input  logic                      sof,
  output logic [9*DATA_WIDTH-1:0]   window_out,
  output logic                      window_valid,
  output logic                      frame_done,
`ifdef CONV_WIN_COORD_EN
  output logic                      frame_err,
  output logic [15:0]               win_row,
  output logic [15:0]               win_col
`else
  output logic                      frame_err
`endif
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned WW = 9 * DATA_WIDTH;
  localparam int unsigned CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [WW-1:0]   win_q, win_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef CONV_WIN_COORD_EN
  logic [15:0]     win_row_q, win_row_d;
  logic [15:0]     win_col_q, win_col_d;
`endif

  logic            acc;
  logic            win_en;
  logic            last_col;
  logic            last_row;
  logic [CW-1:0]   pcol;
  logic [RW-1:0]   prow;
  logic [DW-1:0]   lb0_rd;
  logic [DW-1:0]   lb1_rd;

  logic [DW-1:0]   linebuf0 [IMG_WIDTH];
  logic [DW-1:0]   linebuf1 [IMG_WIDTH];

  // Position of the current pixel: a sof pixel is always (0,0) of a fresh frame
  always_comb begin
    acc      = pix_valid && (sof || (state_q != S_IDLE));
    pcol     = sof ? '0 : col_q;
    prow     = sof ? '0 : row_q;
    last_col = (pcol == CW'(IMG_WIDTH - 1));
    last_row = (prow == RW'(IMG_HEIGHT - 1));
    win_en   = acc && (prow >= RW'(2)) && (pcol >= CW'(2));
    lb0_rd   = linebuf0[pcol];
    lb1_rd   = linebuf1[pcol];
  end

  // Line buffers: shift the column down one row on every accepted pixel
  always_ff @(posedge clk) begin
    if (acc) begin
      linebuf1[pcol] <= lb0_rd;
      linebuf0[pcol] <= pix_in;
    end
  end

  // Next-state, counters, window shift and output pulses
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = pix_valid && sof && (state_q != S_IDLE);
`ifdef CONV_WIN_COORD_EN
    win_row_d = win_row_q;
    win_col_d = win_col_q;
`endif
    if (acc) begin
      // shift every row left; new right column is {lb1, lb0, pix} top to bottom
      for (int r = 0; r < 3; r++) begin
        win_d[(r*3+1)*DW-1 -: DW] = win_q[(r*3+2)*DW-1 -: DW];
        win_d[(r*3+2)*DW-1 -: DW] = win_q[(r*3+3)*DW-1 -: DW];
      end
      win_d[3*DW-1 -: DW] = lb1_rd;
      win_d[6*DW-1 -: DW] = lb0_rd;
      win_d[9*DW-1 -: DW] = pix_in;

      valid_d = win_en;
      done_d  = win_en && last_col && last_row;
`ifdef CONV_WIN_COORD_EN
      if (win_en) begin
        win_row_d = 16'(prow) - 16'd2;
        win_col_d = 16'(pcol) - 16'd2;
      end
`endif
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d   = '0;
          state_d = S_IDLE;
        end else begin
          row_d   = prow + RW'(1);
          state_d = (prow >= RW'(2)) ? S_ACTIVE : S_FILL;
        end
      end else begin
        col_d   = pcol + CW'(1);
        row_d   = prow;
        state_d = (prow >= RW'(2)) ? S_ACTIVE : S_FILL;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      win_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef CONV_WIN_COORD_EN
      win_row_q <= '0;
      win_col_q <= '0;
`endif
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      win_q     <= win_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef CONV_WIN_COORD_EN
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
`endif
    end
  end

  assign window_out   = win_q;
  assign window_valid = valid_q;
  assign frame_done   = done_q;
  assign frame_err    = err_q;
`ifdef CONV_WIN_COORD_EN
  assign win_row      = win_row_q;
  assign win_col      = win_col_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen with a 5x4 image, pixel = row*16+col.
module tb_conv_window_gen;

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 5;
  localparam int unsigned IH = 4;
  localparam int unsigned WW = 9 * DW;

  logic          clk;
  logic          rst;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          sof;
  logic [WW-1:0] window_out;
  logic          window_valid;
  logic          frame_done;
  logic          frame_err;
`ifdef CONV_WIN_COORD_EN
  logic [15:0]   win_row;
  logic [15:0]   win_col;
`endif

  int total;
  int bad;

  // first window (top-left 0,0), element 8 in the top bits
  localparam logic [WW-1:0] FIRST_WIN =
    144'h0022_0021_0020_0012_0011_0010_0002_0001_0000;

  conv_window_gen #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_in       (pix_in),
    .pix_valid    (pix_valid),
    .sof          (sof),
    .window_out   (window_out),
    .window_valid (window_valid),
    .frame_done   (frame_done),
`ifdef CONV_WIN_COORD_EN
    .frame_err    (frame_err),
    .win_row      (win_row),
    .win_col      (win_col)
`else
    .frame_err    (frame_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pixv(input int r, input int c);
    return DW'(r * 16 + c);
  endfunction

  function automatic logic [WW-1:0] exp_win(input int wr, input int wc);
    logic [WW-1:0] e;
    e = '0;
    for (int i = 0; i < 9; i++) e[(i+1)*DW-1 -: DW] = pixv(wr + i / 3, wc + i % 3);
    return e;
  endfunction

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock cycle with the given inputs; outputs are sampled 1 time unit after the edge
  task automatic step(input logic v, input logic s, input logic [DW-1:0] p);
    pix_valid = v;
    sof       = s;
    pix_in    = p;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  // one pixel of a frame at (r,c) with all per-cycle output checks
  task automatic send_pix(input int r, input int c, input logic s, input logic exp_err,
                          inout int nwin);
    logic ev;
    step(1'b1, s, pixv(r, c));
    ev = (r >= 2) && (c >= 2);
    check("window_valid", window_valid, ev);
    check("frame_err", frame_err, exp_err);
    check("frame_done", frame_done, (r == IH - 1) && (c == IW - 1));
    if (ev) begin
      nwin++;
      check("window_out", window_out, exp_win(r - 2, c - 2));
`ifdef CONV_WIN_COORD_EN
      check("win_row", win_row, 16'(r - 2));
      check("win_col", win_col, 16'(c - 2));
`endif
      if (r == 2 && c == 2) check("first_window_const", window_out, FIRST_WIN);
      if (r == IH - 1 && c == IW - 1) check("last_elem8", window_out[WW-1 -: DW], 16'h0034);
    end
  endtask

  task automatic send_frame(input bit gaps, input bit err_first);
    int nwin;
    nwin = 0;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (gaps && ($urandom_range(0, 1) == 1)) begin
          step(1'b0, 1'b0, 16'hdead);
          check("gap_valid", window_valid, 1'b0);
          check("gap_done", frame_done, 1'b0);
        end
        send_pix(r, c, (r == 0 && c == 0), err_first && (r == 0 && c == 0), nwin);
      end
    end
    check("window_count", WW'(nwin), WW'(6));
  endtask

  // frame start up to and including pixel (lr,lc)
  task automatic send_partial(input int lr, input int lc);
    int nwin;
    nwin = 0;
    for (int r = 0; r <= lr; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (r < lr || c <= lc) send_pix(r, c, (r == 0 && c == 0), 1'b0, nwin);
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    pix_in    = '0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_window_out", window_out, '0);
    check("rst_window_valid", window_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
`ifdef CONV_WIN_COORD_EN
    check("rst_win_row", win_row, '0);
    check("rst_win_col", win_col, '0);
`endif
    rst = 1'b0;
    step(1'b0, 1'b0, '0);

    // pixels without sof from reset are ignored
    for (int i = 0; i < IW * IH; i++) begin
      step(1'b1, 1'b0, pixv(i / IW, i % IW));
      check("nosof_valid", window_valid, 1'b0);
      check("nosof_done", frame_done, 1'b0);
    end

    // continuous frame
    send_frame(1'b0, 1'b0);
    step(1'b0, 1'b0, '0);
    check("idle_valid", window_valid, 1'b0);

    // frame with random gaps
    send_frame(1'b1, 1'b0);

    // sof at pixel (2,3) restarts the frame and flags an error
    send_partial(2, 2);
    send_frame(1'b0, 1'b1);
    step(1'b0, 1'b0, '0);
    check("err_single_pulse", frame_err, 1'b0);

    // reset during ACTIVE clears outputs immediately
    send_partial(2, 3);
    #2 rst = 1'b1;
    #1;
    check("midrst_window_out", window_out, '0);
    check("midrst_window_valid", window_valid, 1'b0);
    check("midrst_frame_done", frame_done, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_hold_valid", window_valid, 1'b0);
    // pixels after reset without sof must not produce windows
    step(1'b1, 1'b0, pixv(2, 4));
    check("postrst_nosof_valid", window_valid, 1'b0);
    send_frame(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
